// File: rtl/fifo_rd_stream_adapter.sv
// Registered-read FIFO port to valid/ready stream adapter with a skid buffer.
// Optional counters for transfers and stalled cycles: define FIFO_RD_STREAM_ADAPT_STATS_EN.
module fifo_rd_stream_adapter #(
  parameter int WIDTH      = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_RD_STREAM_ADAPT_STATS_EN
  ,
  output logic [15:0]      xfer_cnt,
  output logic [15:0]      drop_stall
`endif
);

  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int OW = $clog2(SKID_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(SKID_DEPTH - 1);
  localparam logic [OW-1:0] DEPTH    = OW'(SKID_DEPTH);

  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [OW-1:0]    occ;
  logic [OW-1:0]    committed;
  logic             inflight;
  logic             accept;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Slots already promised: words stored plus the word the FIFO returns next cycle.
  always_comb begin
    committed = occ + OW'(inflight);
    out_valid = !rst && (occ != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    pop       = out_valid && out_ready;
    fifo_rd   = !rst && !fifo_empty && ((committed < DEPTH) || pop);
    accept    = fifo_rd && !fifo_empty;
    push      = inflight;
  end

  // NOTE: storage has no reset; occ and the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_rd_data;
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= accept;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_ADAPT_STATS_EN
  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt   <= '0;
      drop_stall <= '0;
    end else begin
      if (pop && (xfer_cnt != 16'hFFFF))
        xfer_cnt <= xfer_cnt + 16'd1;
      if (out_valid && !out_ready && (drop_stall != 16'hFFFF))
        drop_stall <= drop_stall + 16'd1;
    end
  end
`endif

endmodule
